// File: rtl/instr_pkg.sv
// Shared types, field positions, opcode constants and the LEGv8 encode helper.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package instr_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_B  = 3'd3,
        FMT_CB = 3'd4
    } instr_fmt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } enc_state_t;

    // Opcode widths per format
    localparam int OPW_R  = 11;
    localparam int OPW_I  = 10;
    localparam int OPW_D  = 11;
    localparam int OPW_B  = 6;
    localparam int OPW_CB = 8;

    // Field LSB positions inside the instruction word
    localparam int RD_LSB     = 0;
    localparam int RN_LSB     = 5;
    localparam int SHAMT_LSB  = 10;
    localparam int RM_LSB     = 16;
    localparam int I_IMM_LSB  = 10;
    localparam int D_IMM_LSB  = 12;
    localparam int CB_IMM_LSB = 5;
    localparam int B_IMM_LSB  = 0;
    localparam int R_OP_LSB   = 32 - OPW_R;
    localparam int I_OP_LSB   = 32 - OPW_I;
    localparam int D_OP_LSB   = 32 - OPW_D;
    localparam int B_OP_LSB   = 32 - OPW_B;
    localparam int CB_OP_LSB  = 32 - OPW_CB;

    // Common opcodes
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [5:0]  OP_B    = 6'h05;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;

    // A bundle is legal when the format exists and the opcode fits its field
    function automatic logic bundle_legal(logic [2:0] fmt, logic [10:0] op);
        case (fmt)
            3'd0:    return 1'b1;
            3'd1:    return (op >> OPW_I) == 11'd0;
            3'd2:    return 1'b1;
            3'd3:    return (op >> OPW_B) == 11'd0;
            3'd4:    return (op >> OPW_CB) == 11'd0;
            default: return 1'b0;
        endcase
    endfunction

    // Pack decoded fields into a machine word; immediates are truncated to field width
    function automatic logic [`INSTR_LEN-1:0] encode(
        instr_fmt_t  fmt,
        logic [10:0] op,
        logic [4:0]  rm,
        logic [5:0]  shamt,
        logic [4:0]  rn,
        logic [4:0]  rd,
        logic [25:0] imm
    );
        logic [`INSTR_LEN-1:0] w;
        w = '0;
        case (fmt)
            FMT_R: begin
                w[R_OP_LSB +: OPW_R] = op;
                w[RM_LSB +: 5]       = rm;
                w[SHAMT_LSB +: 6]    = shamt;
                w[RN_LSB +: 5]       = rn;
                w[RD_LSB +: 5]       = rd;
            end
            FMT_I: begin
                w[I_OP_LSB +: OPW_I] = op[OPW_I-1:0];
                w[I_IMM_LSB +: 12]   = imm[11:0];
                w[RN_LSB +: 5]       = rn;
                w[RD_LSB +: 5]       = rd;
            end
            FMT_D: begin
                w[D_OP_LSB +: OPW_D] = op;
                w[D_IMM_LSB +: 9]    = imm[8:0];
                w[RN_LSB +: 5]       = rn;
                w[RD_LSB +: 5]       = rd;
            end
            FMT_B: begin
                w[B_OP_LSB +: OPW_B] = op[OPW_B-1:0];
                w[B_IMM_LSB +: 26]   = imm;
            end
            FMT_CB: begin
                w[CB_OP_LSB +: OPW_CB] = op[OPW_CB-1:0];
                w[CB_IMM_LSB +: 19]    = imm[18:0];
                w[RD_LSB +: 5]         = rd;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry FIFO; entry 0 is always the head so rdata comes straight from a register.
module instr_fifo2 #(
    parameter int            W        = 96,
    parameter logic [W-1:0]  RST_DATA = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic [1:0]   cnt;

    assign rdata = mem0;
    assign count = cnt;

    // Shift-style storage: pops move entry 1 into the head slot
    always_ff @(posedge clk) begin
        if (rst) begin
            mem0 <= RST_DATA;
            mem1 <= RST_DATA;
            cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        mem0 <= wdata;
                        cnt  <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        mem1 <= wdata;
                        cnt  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt != 2'd0) begin
                        mem0 <= mem1;
                        cnt  <= cnt - 2'd1;
                    end
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        mem0 <= wdata;
                    end else if (cnt == 2'd2) begin
                        mem0 <= mem1;
                        cnt  <= 2'd1;
                    end else begin
                        mem0 <= wdata;
                        cnt  <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming LEGv8 encoder / program loader: fields in, addressed machine words out.
module instr_encoder #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_fmt,
    input  logic [10:0]            in_opcode,
    input  logic [4:0]             in_rm,
    input  logic [5:0]             in_shamt,
    input  logic [4:0]             in_rn,
    input  logic [4:0]             in_rd,
    input  logic [25:0]            in_imm,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`INSTR_LEN-1:0]  out_instr,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [15:0]            word_count,
    output logic                   err,
    output logic                   done,
    output logic [1:0]             dbg_state
);
    import instr_pkg::*;

    localparam int FIFO_W = ADDR_W + `INSTR_LEN;

    enc_state_t              state;
    logic [ADDR_W-1:0]       next_addr;
    logic [1:0]              fifo_count;
    logic [FIFO_W-1:0]       fifo_head;
    logic [`INSTR_LEN-1:0]   enc_word;
    logic                    accept;
    logic                    legal;
    logic                    push;
    logic                    pop;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on valid, and a producer holding valid
    // keeps its data stable until the transfer. The output word and address
    // hold while out_valid is high and out_ready is low.
    assign in_ready  = (state == S_RUN) && (fifo_count < 2'd2);
    assign accept    = in_valid && in_ready;
    assign legal     = bundle_legal(in_fmt, in_opcode);
    assign enc_word  = encode(instr_fmt_t'(in_fmt), in_opcode, in_rm, in_shamt, in_rn, in_rd, in_imm);
    assign push      = accept && legal;
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign {out_addr, out_instr} = fifo_head;
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    instr_fifo2 #(
        .W        (FIFO_W),
        .RST_DATA ({BASE_ADDR, {`INSTR_LEN{1'b0}}})
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({next_addr, enc_word}),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    // Session FSM plus address, word counter and sticky error bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            next_addr  <= BASE_ADDR;
            word_count <= 16'd0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        next_addr  <= BASE_ADDR;
                        word_count <= 16'd0;
                        err        <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept && in_last) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (fifo_count == 2'd0) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (push) next_addr <= next_addr + ADDR_W'(3'd4);
            if (accept && !legal) err <= 1'b1;
            if (pop && (word_count != 16'hFFFF)) word_count <= word_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: behavioural model with a per-cycle compare, plus directed literal checks.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_instr_encoder;
    import instr_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_fmt = 3'd0;
    logic [10:0] in_opcode = 11'd0;
    logic [4:0]  in_rm = 5'd0;
    logic [5:0]  in_shamt = 6'd0;
    logic [4:0]  in_rn = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [25:0] in_imm = 26'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, err, done;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic [15:0] word_count;
    logic [1:0]  dbg_state;

    logic        w_in_ready, w_out_valid, w_err, w_done;
    logic [31:0] w_out_instr;
    logic [3:0]  w_out_addr;
    logic [15:0] w_word_count;
    logic [1:0]  w_dbg_state;

    instr_encoder #(.ADDR_W(64), .BASE_ADDR(64'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rm(in_rm), .in_shamt(in_shamt),
        .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .word_count(word_count), .err(err), .done(done),
        .dbg_state(dbg_state)
    );

    // Narrow-address instance sharing all inputs, used for the wrap check
    instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) dut_w (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rm(in_rm), .in_shamt(in_shamt),
        .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
        .out_addr(w_out_addr), .word_count(w_word_count), .err(w_err), .done(w_done),
        .dbg_state(w_dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int op_width(int f);
        case (f)
            0: return 11;
            1: return 10;
            2: return 11;
            3: return 6;
            4: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_legal(int f, int unsigned op);
        return (f <= 4) && (op < (32'd1 << op_width(f)));
    endfunction

    function automatic logic [31:0] model_encode(int f, int unsigned op, int unsigned rm,
                                                 int unsigned sh, int unsigned rn,
                                                 int unsigned rd, int unsigned imm);
        case (f)
            0: return (op << 21) | (rm << 16) | (sh << 10) | (rn << 5) | rd;
            1: return (op << 22) | ((imm & 32'hFFF) << 10) | (rn << 5) | rd;
            2: return (op << 21) | ((imm & 32'h1FF) << 12) | (rn << 5) | rd;
            3: return (op << 26) | (imm & 32'h3FF_FFFF);
            4: return (op << 24) | ((imm & 32'h7FFFF) << 5) | rd;
            default: return 32'd0;
        endcase
    endfunction

    // Model session phase: 0 idle, 1 loading, 2 draining, 3 finished
    int          m_state = 0;
    logic [95:0] exp_q[$];          // {addr, instr}
    logic [15:0] m_wc = 16'd0;
    bit          m_err = 1'b0;
    logic [63:0] m_naddr = 64'd0;

    always @(posedge clk) begin
        int  sz;
        bit  rdy, acc, take;
        if (rst) begin
            m_state = 0;
            exp_q.delete();
            m_wc    = 16'd0;
            m_err   = 1'b0;
            m_naddr = 64'd0;
        end else begin
            sz   = exp_q.size();
            rdy  = (m_state == 1) && (sz < 2);
            acc  = in_valid && rdy;
            take = (sz > 0) && out_ready;
            if (take) begin
                void'(exp_q.pop_front());
                if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            end
            if (acc) begin
                if (model_legal(int'(in_fmt), in_opcode)) begin
                    exp_q.push_back({m_naddr, model_encode(int'(in_fmt), in_opcode, in_rm,
                                                           in_shamt, in_rn, in_rd, in_imm)});
                    m_naddr = m_naddr + 64'd4;
                end else begin
                    m_err = 1'b1;
                end
            end
            case (m_state)
                0: if (start) begin
                       m_state = 1; m_wc = 16'd0; m_err = 1'b0; m_naddr = 64'd0;
                   end
                1: if (acc && in_last) m_state = 2;
                2: if (sz == 0) m_state = 3;
                default: m_state = 0;
            endcase
        end
    end

    // ---------------- compare process and output log ----------------
    logic [95:0] got_q[$];
    logic [35:0] w_got_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            #2;
            check("in_ready", 64'(in_ready), 64'((m_state == 1) && (exp_q.size() < 2)));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
                check("out_addr", out_addr, exp_q[0][95:32]);
            end
            check("word_count", 64'(word_count), 64'(m_wc));
            check("err", 64'(err), 64'(m_err));
            check("done", 64'(done), 64'(m_state == 3));
            check("dbg_state", 64'(dbg_state), 64'(m_state));
            if (out_valid && out_ready) got_q.push_back({out_addr, out_instr});
            if (w_out_valid && out_ready) w_got_q.push_back({w_out_addr, w_out_instr});
        end
    end

    always @(negedge clk) begin
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] f, input logic [10:0] op, input logic [4:0] rm,
                        input logic [5:0] sh, input logic [4:0] rn, input logic [4:0] rd,
                        input logic [25:0] imm, input logic last);
        int n = 0;
        @(negedge clk);
        in_fmt = f; in_opcode = op; in_rm = rm; in_shamt = sh;
        in_rn = rn; in_rd = rd; in_imm = imm; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic send_random(input logic last);
        int f;
        int unsigned op;
        f  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
        if (f > 4 || $urandom_range(0, 9) == 0) op = $urandom_range(0, 2047);
        else op = $urandom_range(0, (1 << op_width(f)) - 1);
        send(3'(f), 11'(op), 5'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
             26'($urandom), last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_addr", out_addr, 64'd0);
        check("rst_w_out_addr", 64'(w_out_addr), 64'd12);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        // pin the model against hand-computed words
        check("pin_ldur", 64'(model_encode(2, OP_LDUR, 0, 0, 22, 9, 240)), 64'h F84F02C9);
        check("pin_addi", 64'(model_encode(1, OP_ADDI, 0, 0, 2, 1, 5)), 64'h91001441);
        check("pin_cbz", 64'(model_encode(4, OP_CBZ, 0, 0, 0, 9, 8)), 64'hB4000109);

        // session 1: LDUR / ADD / STUR
        out_ready = 1'b1;
        got_q.delete(); w_got_q.delete();
        do_start();
        send(3'd2, OP_LDUR, 5'd0, 6'd0, 5'd22, 5'd9, 26'd240, 1'b0);
        send(3'd0, OP_ADD, 5'd9, 6'd0, 5'd21, 5'd10, 26'd0, 1'b0);
        send(3'd2, OP_STUR, 5'd0, 6'd0, 5'd23, 5'd10, 26'd64, 1'b1);
        wait_done();
        check("s1_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            check("s1_w0", got_q[0][95:0] ^ 96'd0 >> 0, {64'd0, 32'hF84F02C9});
            check("s1_w1_instr", 64'(got_q[1][31:0]), 64'h8B0902AA);
            check("s1_w1_addr", got_q[1][95:32], 64'd4);
            check("s1_w2_instr", 64'(got_q[2][31:0]), 64'hF80402EA);
            check("s1_w2_addr", got_q[2][95:32], 64'd8);
        end
        check("s1_word_count", 64'(word_count), 64'd3);
        check("wrap_count", 64'(w_got_q.size()), 64'd3);
        if (w_got_q.size() == 3) begin
            check("wrap_a0", 64'(w_got_q[0][35:32]), 64'd12);
            check("wrap_a1", 64'(w_got_q[1][35:32]), 64'd0);
            check("wrap_a2", 64'(w_got_q[2][35:32]), 64'd4);
            check("wrap_i1", 64'(w_got_q[1][31:0]), 64'h8B0902AA);
        end

        // session 2: ADDI / B / CBZ
        got_q.delete();
        do_start();
        send(3'd1, 11'(OP_ADDI), 5'd0, 6'd0, 5'd2, 5'd1, 26'd5, 1'b0);
        send(3'd3, 11'(OP_B), 5'd0, 6'd0, 5'd0, 5'd0, 26'd3, 1'b0);
        send(3'd4, 11'(OP_CBZ), 5'd0, 6'd0, 5'd0, 5'd9, 26'd8, 1'b1);
        wait_done();
        check("s2_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            check("s2_addi", 64'(got_q[0][31:0]), 64'h91001441);
            check("s2_b", 64'(got_q[1][31:0]), 64'h14000003);
            check("s2_cbz", 64'(got_q[2][31:0]), 64'hB4000109);
            check("s2_cbz_addr", got_q[2][95:32], 64'd8);
        end

        // session 3: consumer stall with a full FIFO
        got_q.delete();
        out_ready = 1'b0;
        do_start();
        send(3'd2, OP_LDUR, 5'd0, 6'd0, 5'd22, 5'd9, 26'd240, 1'b0);
        send(3'd0, OP_ADD, 5'd9, 6'd0, 5'd21, 5'd10, 26'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_instr", 64'(out_instr), 64'hF84F02C9);
            check("stall_addr", out_addr, 64'd0);
        end
        out_ready = 1'b1;
        send(3'd2, OP_STUR, 5'd0, 6'd0, 5'd23, 5'd10, 26'd64, 1'b1);
        wait_done();
        check("stall_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            check("stall_w0", 64'(got_q[0][31:0]), 64'hF84F02C9);
            check("stall_w1", 64'(got_q[1][31:0]), 64'h8B0902AA);
            check("stall_w2", 64'(got_q[2][31:0]), 64'hF80402EA);
            check("stall_a2", got_q[2][95:32], 64'd8);
        end

        // session 4: illegal bundles are dropped and flagged
        got_q.delete();
        do_start();
        send(3'd6, 11'd0, 5'd1, 6'd2, 5'd3, 5'd4, 26'd5, 1'b0);
        send(3'd3, 11'h45, 5'd0, 6'd0, 5'd0, 5'd0, 26'd7, 1'b0);
        @(negedge clk);
        #1;
        check("ill_err_set", 64'(err), 64'd1);
        check("ill_no_output", 64'(out_valid), 64'd0);
        send(3'd3, 11'(OP_B), 5'd0, 6'd0, 5'd0, 5'd0, 26'd1, 1'b1);
        wait_done();
        check("ill_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) begin
            check("ill_word", 64'(got_q[0][31:0]), 64'h14000001);
            check("ill_addr", got_q[0][95:32], 64'd0);
        end
        check("ill_err_sticky", 64'(err), 64'd1);
        do_start();
        #1;
        check("ill_err_clear", 64'(err), 64'd0);
        send(3'd6, 11'd0, 5'd0, 6'd0, 5'd0, 5'd0, 26'd0, 1'b1);
        wait_done();
        check("ill_last_err", 64'(err), 64'd1);

        // session 5: reset with words buffered
        out_ready = 1'b0;
        do_start();
        send(3'd0, OP_ADD, 5'd1, 6'd2, 5'd3, 5'd4, 26'd0, 1'b0);
        send(3'd0, OP_ADD, 5'd5, 6'd6, 5'd7, 5'd8, 26'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        do_start();
        #1;
        check("mid_rst_restart", 64'(dbg_state), 64'd1);
        send(3'd1, 11'(OP_ADDI), 5'd0, 6'd0, 5'd2, 5'd1, 26'd5, 1'b1);
        wait_done();

        // randomized sessions with a randomly stalling consumer
        rand_rdy = 1'b1;
        for (int s = 0; s < 25; s++) begin
            int nb;
            nb = $urandom_range(1, 8);
            do_start();
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_random(b == nb - 1);
            end
            wait_done();
        end
        rand_rdy = 1'b0;

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming LEGv8 machine-code encoder and program loader: accepts decoded instruction fields over a valid/ready handshake and packs them into `INSTR_LEN`-bit words (R, I, D, B, CB formats).
- Buffers encoded words in a 2-entry FIFO and emits each with a sequential byte address, for writing into instruction memory.
- It is the inverse of instr_parse; used by the program-load path and as a golden encoder in decode benches.

Parameters:
- ADDR_W, 64, width of out_addr (byte address).
- BASE_ADDR, 0, byte address of the first emitted word after start.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session; honoured only in IDLE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept the bundle this cycle.
- in_fmt  in  3  format code (instr_fmt_t): R=0, I=1, D=2, B=3, CB=4; 5-7 illegal.
- in_opcode  in  11  opcode, right-justified to the format's opcode width.
- in_rm  in  5  Rm (R only).
- in_shamt  in  6  shamt (R only).
- in_rn  in  5  Rn (R, I, D).
- in_rd  in  5  Rd/Rt (R, I, D, CB).
- in_imm  in  26  immediate/address, right-justified: I imm12, D dt_address9, B br_address26, CB cond_br_address19.
- in_last  in  1  final bundle of the session.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes the word.
- out_instr  out  `INSTR_LEN`  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- word_count  out  16  words emitted this session.
- err  out  1  sticky; set on any dropped illegal bundle.
- done  out  1  one-cycle pulse when the session completes.

Behaviour:
- Reset: state IDLE; FIFO empty; in_ready=0; out_valid=0; out_instr=0; out_addr=BASE_ADDR; word_count=0; err=0; done=0.
- FSM:
  - IDLE -> RUN on start. In RUN, start is ignored. On start: clear word_count, clear err, set next address = BASE_ADDR.
  - RUN -> DRAIN on an accepted bundle with in_last=1.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
- Handshake:
  - in_ready = (state==RUN) && fifo_count<2. No push while full, even if a pop occurs in the same cycle.
  - Accept = in_valid && in_ready.
  - Out transfer = out_valid && out_ready.
  - out_instr and out_addr hold stable while out_valid && !out_ready.
- Latency: a bundle accepted at edge N is encoded combinationally and pushed at N. out_valid is high after edge N if the FIFO was empty, i.e. 1-cycle latency.
- Encoding (bit 31 on the left):
  - R: opcode[10:0] | rm | shamt | rn | rd.
  - I: opcode[9:0] | imm[11:0] | rn | rd.
  - D: opcode[10:0] | imm[8:0] | 2'b00 | rn | rd.
  - B: opcode[5:0] | imm[25:0].
  - CB: opcode[7:0] | imm[18:0] | rd.
  - Unused imm bits are ignored; the caller supplies two's-complement offsets truncated to field width.
- Illegal bundle:
  - Conditions: fmt 5-7, or opcode bits set above the format's opcode width.
  - Action: the bundle is accepted but not pushed, and err is set. The address does not advance.
  - An illegal bundle with in_last=1 still moves the FSM to DRAIN.
- Address:
  - Each pushed word takes the next address; the next address increments by 4 per push.
  - The address wraps modulo 2^ADDR_W.
  - word_count increments per out transfer and saturates at 16'hFFFF.
- Simultaneous push and pop on a non-full FIFO: count unchanged, order preserved.
- rst mid-session: everything returns to the reset values the next cycle; FIFO contents are discarded and no done pulse is issued.

Decomposition:
- Package instr_pkg holds:
  - instr_fmt_t enum.
  - Opcode widths per format: 11/10/11/6/8.
  - Field-position localparams.
  - Common opcode constants: ADD=11'h458, LDUR=11'h7C2, STUR=11'h7C0, ADDI=10'h244, B=6'h05, CBZ=8'hB4.
  - Uses the shared `INSTR_LEN` define.
- Sub-module instr_fifo2: a 2-entry FIFO of {instr, addr} with push/pop/count. The encode function lives in instr_pkg.

Test Plan:
- start, BASE_ADDR=0, out_ready=1; push D LDUR rn=22 rd=9 imm=240, then R ADD rm=9 rn=21 rd=10, then D STUR rn=23 rd=10 imm=64 with last -> words 0xF84F02C9@0, 0x8B0902AA@4, 0xF80402EA@8; done pulse one cycle after the FIFO empties; word_count=3.
- I ADDI rn=2 rd=1 imm=5; B opcode=5 imm=3; CB CBZ rd=9 imm=8 -> 0x91001441, 0x14000003, 0xB4000109.
- out_ready=0, push 3 bundles -> in_ready drops after 2 pushes; out_instr stable; release out_ready -> all 3 words delivered in order with no loss.
- fmt=6, then B with opcode=7'h45 -> both dropped, err=1, no address advance; the next legal word goes out at the unchanged address; err clears on the next start.
- ADDR_W=4, BASE_ADDR=12 -> second word at address 0 (wrap).
- rst asserted with 2 words buffered -> out_valid=0 and state IDLE next cycle; no done; start is accepted afterward.
